// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
//   Shared types and constants for the instruction-memory program loader.
//   - loader_state_t : loader FSM state encoding
//   - HDR_W          : width of the word-count header (two bytes)
//   - BYTES_PER_WORD : host bytes packed into one instruction word
//   - WORD_W         : instruction word width
//   - is_ready_state : states in which the loader accepts host bytes
package imem_loader_pkg;

  localparam int HDR_W          = 16;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR_HI = 3'd1,
    HDR_LO = 3'd2,
    DATA   = 3'd3,
    CSUM   = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } loader_state_t;

  function automatic logic is_ready_state(input loader_state_t s);
    return (s == HDR_HI) || (s == HDR_LO) || (s == DATA) || (s == CSUM);
  endfunction

endpackage

// File: rtl/imem_word_packer.sv
// imem_word_packer
//   Packs a big-endian byte stream into 32-bit instruction words. The first
//   byte of each word lands in word_data[31:24], the fourth in [7:0].
// Ports
//   clk, reset  : clock, asynchronous active-low reset
//   clear       : restart packing at byte 0 (new image)
//   byte_en     : byte_in is consumed this cycle
//   byte_in     : host byte
//   word_done   : combinational, the byte consumed this cycle completes a word
//   word_valid  : one-cycle strobe, word_data holds a complete word
//   word_data   : last completed word (held between strobes)
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_en,
  input  logic [7:0]        byte_in,
  output logic              word_done,
  output logic              word_valid,
  output logic [WORD_W-1:0] word_data
);

  localparam int                IDX_W    = $clog2(BYTES_PER_WORD);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BYTES_PER_WORD - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  logic [IDX_W-1:0]    idx_q;
  logic [WORD_W-9:0]   partial_q;

  assign word_done = byte_en && (idx_q == IDX_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q      <= '0;
      partial_q  <= '0;
      word_valid <= 1'b0;
      word_data  <= '0;
    end else begin
      word_valid <= word_done;
      if (clear) begin
        idx_q     <= '0;
        partial_q <= '0;
      end else if (byte_en) begin
        if (word_done) begin
          word_data <= {partial_q, byte_in};
          idx_q     <= '0;
        end else begin
          partial_q <= {partial_q[WORD_W-17:0], byte_in};
          idx_q     <= idx_q + IDX_ONE;
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader
//   Writer side of the instruction memory. Receives a host byte stream framed
//   as a 16-bit big-endian word count N followed by N big-endian 32-bit words,
//   writes them to consecutive word addresses from 0, and holds the CPU in
//   reset until a complete image is present.
//   Optional feature macro: IMEM_LOADER_CSUM_EN -- a trailing byte equal to
//   the XOR of all header and payload bytes is required before DONE.
// Ports
//   clk, reset  : clock, asynchronous active-low reset
//   start       : one-cycle pulse, begins a load from IDLE, DONE or ERR
//   rx_valid    : host byte valid
//   rx_data     : host byte
//   rx_ready    : loader accepts a byte (transfer on rx_valid & rx_ready)
//   mem_we      : instruction memory write strobe, one cycle per word
//   mem_waddr   : word address of the write
//   mem_wdata   : instruction word
//   cpu_hold    : CPU reset request, low only while a valid image is present
//   done        : image fully written
//   error       : load aborted (oversize header or checksum mismatch)
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | after reset, waiting for start
// HDR_HI | waiting for word-count high byte
// HDR_LO | waiting for word-count low byte, size check on transfer
// DATA   | receiving payload bytes, one memory write per four bytes
// CSUM   | waiting for the checksum byte (checksum build only)
// DONE   | image complete, CPU released
// ERR    | load aborted, CPU held
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam logic [HDR_W-1:0] DEPTH_N = HDR_W'(DEPTH);
  localparam logic [ADDR_W:0]  CNT_ONE = (ADDR_W + 1)'(1);

`ifdef IMEM_LOADER_CSUM_EN
  localparam loader_state_t POST_DATA = CSUM;
`else
  localparam loader_state_t POST_DATA = DONE;
`endif

  loader_state_t state_q, state_d;

  logic [7:0]       n_hi_q;
  logic [HDR_W-1:0] n_q;
  logic [ADDR_W:0]  word_cnt_q;

  logic             xfer;
  logic             load_start;
  logic             byte_en;
  logic             word_done;
  logic             last_word;
  logic [HDR_W-1:0] n_rx;
  logic [HDR_W-1:0] cnt_next_ext;

  assign xfer       = rx_valid && rx_ready;
  assign load_start = start && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));
  assign byte_en    = xfer && (state_q == DATA);

  // Full word count as it stands once the low header byte arrives.
  assign n_rx = {n_hi_q, rx_data};

  // The word being completed is the last one when (words so far + 1) == N.
  assign cnt_next_ext = HDR_W'(word_cnt_q) + HDR_W'(1);
  assign last_word    = (cnt_next_ext == n_q);

`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0] csum_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      csum_q <= '0;
    end else if (load_start) begin
      csum_q <= '0;
    end else if (xfer && (state_q != CSUM)) begin
      csum_q <= csum_q ^ rx_data;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = HDR_HI;
      end
      HDR_HI: begin
        if (xfer) state_d = HDR_LO;
      end
      HDR_LO: begin
        if (xfer) begin
          if (n_rx > DEPTH_N) begin
            state_d = ERR;
          end else if (n_rx == '0) begin
            state_d = POST_DATA;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (word_done && last_word) state_d = POST_DATA;
      end
`ifdef IMEM_LOADER_CSUM_EN
      CSUM: begin
        if (xfer) state_d = (rx_data == csum_q) ? DONE : ERR;
      end
`endif
      DONE, ERR: begin
        if (start) state_d = HDR_HI;
      end
      default: state_d = IDLE;
    endcase
  end

  // rx_ready is registered alongside the state so it never depends on rx_valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      rx_ready <= 1'b0;
    end else begin
      state_q  <= state_d;
      rx_ready <= is_ready_state(state_d);
    end
  end

  // The write address is captured with the word so that it is valid in the
  // same cycle as the mem_we strobe; the counter itself has already moved on.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_hi_q     <= '0;
      n_q        <= '0;
      word_cnt_q <= '0;
      mem_waddr  <= '0;
    end else begin
      if (load_start) begin
        word_cnt_q <= '0;
      end
      if (xfer && (state_q == HDR_HI)) begin
        n_hi_q <= rx_data;
      end
      if (xfer && (state_q == HDR_LO)) begin
        n_q <= n_rx;
      end
      if (word_done) begin
        mem_waddr  <= word_cnt_q[ADDR_W-1:0];
        word_cnt_q <= word_cnt_q + CNT_ONE;
      end
    end
  end

  imem_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (load_start),
    .byte_en    (byte_en),
    .byte_in    (rx_data),
    .word_done  (word_done),
    .word_valid (mem_we),
    .word_data  (mem_wdata)
  );

  assign cpu_hold = (state_q != DONE);
  assign done     = (state_q == DONE);
  assign error    = (state_q == ERR);

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
//   Bench for imem_loader: directed loads from the test plan plus randomized
//   loads, all compared against a byte-stream reference model. Build with
//   IMEM_LOADER_CSUM_EN defined to exercise the checksum variant.
module tb_imem_loader;

  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;
`ifdef IMEM_LOADER_CSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  typedef struct {
    int unsigned addr;
    logic [31:0] data;
  } wr_t;

  logic              clk      = 1'b0;
  logic              reset    = 1'b0;
  logic              start    = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data  = 8'h00;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;

  int  n_checks = 0;
  int  n_pass   = 0;
  int  cyc      = 0;
  wr_t exp_q[$];
  wr_t mon_e;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
  endtask

  // Every write strobe must match the next expected (addr, data) pair.
  always @(negedge clk) begin
    if (reset && mem_we) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_we", 32'(mem_we), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("waddr", 32'(mem_waddr), mon_e.addr);
        check_eq("wdata", mem_wdata, mon_e.data);
      end
    end
  end

  function automatic void rand_bytes(input int cnt, output logic [7:0] q[$]);
    q.delete();
    for (int k = 0; k < cnt; k++) q.push_back(8'($urandom));
  endfunction

  // Reference model: word k is bytes 4k..4k+3, most significant first.
  function automatic void push_expected(input int n, input logic [7:0] pl[$]);
    wr_t e;
    if (n > DEPTH) return;
    for (int k = 0; k < n; k++) begin
      e.addr = k;
      e.data = pl[4*k] * 32'd16777216 + pl[4*k+1] * 32'd65536 + pl[4*k+2] * 32'd256 + 32'(pl[4*k+3]);
      exp_q.push_back(e);
    end
  endfunction

  function automatic void build_stream(input int n, input logic [7:0] pl[$], input bit bad_csum,
                                       output logic [7:0] s[$]);
    logic [7:0] x;
    s.delete();
    s.push_back(8'(n / 256));
    s.push_back(8'(n % 256));
    if (n <= DEPTH) begin
      foreach (pl[i]) s.push_back(pl[i]);
      if (CSUM_EN) begin
        x = 8'h00;
        foreach (s[i]) x = x ^ s[i];
        s.push_back(bad_csum ? (x ^ 8'h01) : x);
      end
    end
  endfunction

  // Called at a negedge; returns at the negedge after the last transfer.
  task automatic send_bytes(input logic [7:0] q[$], input int stall_pct, input int stall_at,
                            input int stall_len, input int glitch_at);
    int i       = 0;
    int stalled = 0;
    int budget  = 0;
    bit glitched = 1'b0;
    while (i < q.size() && budget < 4000) begin
      start = (i == glitch_at) && !glitched;
      if (start) glitched = 1'b1;
      if (i == stall_at && stalled < stall_len) begin
        rx_valid = 1'b0;
        stalled++;
        if (stalled == stall_len) begin
          check_eq("stall_ready", 32'(rx_ready), 32'd1);
          check_eq("stall_we", 32'(mem_we), 32'd0);
          check_eq("stall_done", 32'(done), 32'd0);
        end
      end else if (stall_pct > 0 && $urandom_range(99) < stall_pct) begin
        rx_valid = 1'b0;
      end else begin
        rx_valid = 1'b1;
        rx_data  = q[i];
      end
      if (rx_valid && rx_ready) i++;
      @(negedge clk);
      budget++;
    end
    rx_valid = 1'b0;
    start    = 1'b0;
    if (i < q.size()) check_eq("send_timeout", i, q.size());
  endtask

  task automatic run_load(input int n, input logic [7:0] pl[$], input int stall_pct, input int stall_at,
                          input int stall_len, input int glitch_at, input bit bad_csum);
    logic [7:0] s[$];
    bit exp_err;
    int exp_lat;
    int t_start;
    int w;
    exp_err = (n > DEPTH) || (CSUM_EN && bad_csum);
    exp_lat = (n > DEPTH) ? 2 : (2 + 4 * n + (CSUM_EN ? 1 : 0));
    push_expected(n, pl);
    build_stream(n, pl, bad_csum, s);
    start   = 1'b1;
    t_start = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    check_eq("hold_on_start", 32'(cpu_hold), 32'd1);
    check_eq("ready_on_start", 32'(rx_ready), 32'd1);
    send_bytes(s, stall_pct, stall_at, stall_len, glitch_at);
    w = 0;
    while (!(done || error) && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (stall_pct == 0 && stall_len == 0) check_eq("latency", cyc - t_start, exp_lat);
    @(negedge clk);
    check_eq("done", 32'(done), 32'(!exp_err));
    check_eq("error", 32'(error), 32'(exp_err));
    check_eq("cpu_hold", 32'(cpu_hold), 32'(exp_err));
    check_eq("rx_ready_end", 32'(rx_ready), 32'd0);
    check_eq("writes_left", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic check_reset_values(input string pfx);
    check_eq({pfx, "_rx_ready"}, 32'(rx_ready), 32'd0);
    check_eq({pfx, "_mem_we"}, 32'(mem_we), 32'd0);
    check_eq({pfx, "_mem_waddr"}, 32'(mem_waddr), 32'd0);
    check_eq({pfx, "_mem_wdata"}, mem_wdata, 32'd0);
    check_eq({pfx, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    check_eq({pfx, "_done"}, 32'(done), 32'd0);
    check_eq({pfx, "_error"}, 32'(error), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pl[$];
    logic [7:0] s[$];
    logic [7:0] part[$];
    int n;

    #12;
    check_reset_values("rst");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    pl = '{8'h20, 8'h01, 8'h00, 8'h01, 8'h20, 8'h23, 8'h00, 8'h03};
    run_load(2, pl, 0, -1, 0, -1, 1'b0);

    pl.delete();
    run_load(0, pl, 0, -1, 0, -1, 1'b0);

    run_load(257, pl, 0, -1, 0, -1, 1'b0);

    // host stalls 5 cycles after the 2nd data byte (stream index 4 is the 3rd)
    rand_bytes(12, pl);
    run_load(3, pl, 0, 4, 5, -1, 1'b0);

    // reset during the 3rd word, then reload from address 0
    rand_bytes(16, pl);
    push_expected(4, pl);
    build_stream(4, pl, 1'b0, s);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    part = s[0:11];
    send_bytes(part, 0, -1, 0, -1);
    reset = 1'b0;
    #1;
    check_reset_values("midrst");
    check_eq("midrst_writes_left", exp_q.size(), 32'd2);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    rand_bytes(8, pl);
    run_load(2, pl, 0, -1, 0, -1, 1'b0);

    rand_bytes(4 * DEPTH, pl);
    run_load(DEPTH, pl, 0, -1, 0, -1, 1'b0);

    rand_bytes(8, pl);
    run_load(2, pl, 0, -1, 0, -1, 1'b1);

    for (int t = 0; t < 10; t++) begin
      if ($urandom_range(3) == 0) n = $urandom_range(65535, DEPTH + 1);
      else n = $urandom_range(10);
      rand_bytes((n > DEPTH) ? 0 : 4 * n, pl);
      run_load(n, pl, ($urandom_range(1) == 1) ? 25 : 0, -1, 0,
               $urandom_range(6), 1'($urandom_range(1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
